// File: rtl/veer_sram_pkg.sv
// ---------------------------------------------------------------------------
// veer_sram_pkg
//   Shared types and constants for the VeeR EL2 closely-coupled memory
//   export block: bank geometry, the error-injection mode struct and the
//   helper that turns a memory's mode bits into a write flip mask.
// ---------------------------------------------------------------------------
package veer_sram_pkg;

  localparam int BANK_ADDR_W = 13;
  localparam int BANK_DATA_W = 39;
  localparam int BANK_DEPTH  = 8192;

  // Bit order matches the 4-bit mode input: [3] DCCM 2-bit ... [0] ICCM 1-bit.
  typedef struct packed {
    logic dccm_double_bit_error;
    logic dccm_single_bit_error;
    logic iccm_double_bit_error;
    logic iccm_single_bit_error;
  } veer_sram_error_injection_mode_t;

  // Double-bit injection wins over single-bit when both are requested.
  function automatic logic [BANK_DATA_W-1:0] inject_flip_mask(
    input logic single_bit,
    input logic double_bit
  );
    logic [BANK_DATA_W-1:0] mask;
    if (double_bit) begin
      mask = {{(BANK_DATA_W-2){1'b0}}, 2'b11};
    end else if (single_bit) begin
      mask = {{(BANK_DATA_W-1){1'b0}}, 1'b1};
    end else begin
      mask = {BANK_DATA_W{1'b0}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/veer_ccm_sram_export_if.sv
// ---------------------------------------------------------------------------
// veer_ccm_sram_export_if
//   Bundle of the exported ICCM/DCCM bank signals plus the error-injection
//   mode. Flat per-bank buses: bank b address at [b*13 +: 13], bank b word at
//   [b*39 +: 39].
//   master : core side (drives enables/addresses/data/mode, reads dout)
//   slave  : memory side (receives requests, drives dout)
// ---------------------------------------------------------------------------
interface veer_ccm_sram_export_if
  import veer_sram_pkg::*;
#(
  parameter int NUM_BANKS = 4
);

  logic [3:0]                         sram_error_injection_mode;

  logic [NUM_BANKS-1:0]               iccm_clken;
  logic [NUM_BANKS-1:0]               iccm_wren_bank;
  logic [NUM_BANKS*BANK_ADDR_W-1:0]   iccm_addr_bank;
  logic [NUM_BANKS*BANK_DATA_W-1:0]   iccm_bank_wr_data;
  logic [NUM_BANKS*BANK_DATA_W-1:0]   iccm_bank_dout;

  logic [NUM_BANKS-1:0]               dccm_clken;
  logic [NUM_BANKS-1:0]               dccm_wren_bank;
  logic [NUM_BANKS*BANK_ADDR_W-1:0]   dccm_addr_bank;
  logic [NUM_BANKS*BANK_DATA_W-1:0]   dccm_wr_data_bank;
  logic [NUM_BANKS*BANK_DATA_W-1:0]   dccm_bank_dout;

  modport master (
    output sram_error_injection_mode,
    output iccm_clken, iccm_wren_bank, iccm_addr_bank, iccm_bank_wr_data,
    output dccm_clken, dccm_wren_bank, dccm_addr_bank, dccm_wr_data_bank,
    input  iccm_bank_dout, dccm_bank_dout
  );

  modport slave (
    input  sram_error_injection_mode,
    input  iccm_clken, iccm_wren_bank, iccm_addr_bank, iccm_bank_wr_data,
    input  dccm_clken, dccm_wren_bank, dccm_addr_bank, dccm_wr_data_bank,
    output iccm_bank_dout, dccm_bank_dout
  );

endinterface

// File: rtl/ccm_bank_sram.sv
// ---------------------------------------------------------------------------
// ccm_bank_sram
//   Behavioural single-port RAM bank, one-cycle registered read.
//   clk   in  rising-edge clock
//   rst_b in  async active-low reset (clears rdata only, contents kept)
//   cs    in  bank select
//   we    in  write enable (qualified by cs)
//   addr  in  word address
//   wdata in  write word
//   rdata out read word, held when not reading
// ---------------------------------------------------------------------------
module ccm_bank_sram
  import veer_sram_pkg::*;
#(
  parameter int DEPTH  = BANK_DEPTH,
  parameter int DATA_W = BANK_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     cs,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  // Plain unpacked array so a bench can reach it hierarchically.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Next read word: load on a read cycle, otherwise hold (writes do not forward).
  always_comb begin
    rdata_d = rdata_q;
    if (cs && !we) begin
      rdata_d = mem[addr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read register and storage; a write is dropped while reset is asserted.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      rdata_q <= rdata_d;
      if (cs && we) begin
        mem[addr] <= wdata;
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/veer_ccm_sram_export.sv
// ---------------------------------------------------------------------------
// veer_ccm_sram_export
//   Sink for the VeeR EL2 exported ICCM/DCCM: NUM_BANKS independent banks per
//   memory, 39-bit words stored exactly as written (ECC is never computed),
//   with optional 1- or 2-bit error injection on writes.
//   clk   in  core clock
//   rst_b in  async active-low reset (clears all dout, keeps contents)
//   bus   slave side of veer_ccm_sram_export_if (requests, mode, dout)
// ---------------------------------------------------------------------------
module veer_ccm_sram_export
  import veer_sram_pkg::*;
#(
  parameter int NUM_BANKS = 4
) (
  input  logic                         clk,
  input  logic                         rst_b,
  veer_ccm_sram_export_if.slave        bus
);

  veer_sram_error_injection_mode_t mode_s;
  logic [BANK_DATA_W-1:0]          iccm_flip_s;
  logic [BANK_DATA_W-1:0]          dccm_flip_s;
  logic [BANK_DATA_W-1:0]          iccm_rdata_s [NUM_BANKS];
  logic [BANK_DATA_W-1:0]          dccm_rdata_s [NUM_BANKS];

  // Per-memory flip masks, taken from the mode in the same cycle as the write.
  always_comb begin
    mode_s      = veer_sram_error_injection_mode_t'(bus.sram_error_injection_mode);
    iccm_flip_s = inject_flip_mask(mode_s.iccm_single_bit_error,
                                   mode_s.iccm_double_bit_error);
    dccm_flip_s = inject_flip_mask(mode_s.dccm_single_bit_error,
                                   mode_s.dccm_double_bit_error);
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    ccm_bank_sram #(
      .DEPTH  (BANK_DEPTH),
      .DATA_W (BANK_DATA_W)
    ) u_iccm (
      .clk   (clk),
      .rst_b (rst_b),
      .cs    (bus.iccm_clken[b]),
      .we    (bus.iccm_wren_bank[b]),
      .addr  (bus.iccm_addr_bank[b*BANK_ADDR_W +: BANK_ADDR_W]),
      .wdata (bus.iccm_bank_wr_data[b*BANK_DATA_W +: BANK_DATA_W] ^ iccm_flip_s),
      .rdata (iccm_rdata_s[b])
    );

    ccm_bank_sram #(
      .DEPTH  (BANK_DEPTH),
      .DATA_W (BANK_DATA_W)
    ) u_dccm (
      .clk   (clk),
      .rst_b (rst_b),
      .cs    (bus.dccm_clken[b]),
      .we    (bus.dccm_wren_bank[b]),
      .addr  (bus.dccm_addr_bank[b*BANK_ADDR_W +: BANK_ADDR_W]),
      .wdata (bus.dccm_wr_data_bank[b*BANK_DATA_W +: BANK_DATA_W] ^ dccm_flip_s),
      .rdata (dccm_rdata_s[b])
    );
  end

  // Pack the per-bank registered read words back onto the flat dout buses.
  always_comb begin
    bus.iccm_bank_dout = {(NUM_BANKS*BANK_DATA_W){1'b0}};
    bus.dccm_bank_dout = {(NUM_BANKS*BANK_DATA_W){1'b0}};
    for (int b = 0; b < NUM_BANKS; b++) begin
      bus.iccm_bank_dout[b*BANK_DATA_W +: BANK_DATA_W] = iccm_rdata_s[b];
      bus.dccm_bank_dout[b*BANK_DATA_W +: BANK_DATA_W] = dccm_rdata_s[b];
    end
  end

endmodule

// File: tb/tb_veer_ccm_sram_export.sv
// ---------------------------------------------------------------------------
// tb_veer_ccm_sram_export
//   Self-checking bench: directed scenarios with literal expectations, then
//   randomized traffic on both memories against a word-level memory model.
// ---------------------------------------------------------------------------
module tb_veer_ccm_sram_export;
  import veer_sram_pkg::*;

  localparam int NB = 4;
  localparam int W  = BANK_DATA_W;
  localparam int AW = BANK_ADDR_W;

  logic clk = 1'b0;
  logic rst_b;

  veer_ccm_sram_export_if #(.NUM_BANKS(NB)) bus();

  veer_ccm_sram_export #(.NUM_BANKS(NB)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: key = {memory(0=ICCM,1=DCCM), bank, address}.
  logic [W-1:0] model_mem [bit [15:0]];
  logic [W-1:0] exp_dout  [2][NB];

  function automatic logic [W-1:0] dout_of(int m, int b);
    if (m == 1) return bus.dccm_bank_dout[b*W +: W];
    else        return bus.iccm_bank_dout[b*W +: W];
  endfunction

  function automatic logic [W-1:0] flip_of(int m, logic [3:0] mode);
    logic dbl, sgl;
    dbl = (m == 1) ? mode[3] : mode[1];
    sgl = (m == 1) ? mode[2] : mode[0];
    if (dbl)      return 39'd3;
    else if (sgl) return 39'd1;
    else          return 39'd0;
  endfunction

  // Reference behaviour at each rising edge.
  always @(posedge clk) begin
    if (rst_b === 1'b1) begin
      for (int m = 0; m < 2; m++) begin
        for (int b = 0; b < NB; b++) begin
          logic en, we;
          logic [AW-1:0] a;
          logic [W-1:0] d;
          bit [15:0] key;
          en = (m == 1) ? bus.dccm_clken[b] : bus.iccm_clken[b];
          we = (m == 1) ? bus.dccm_wren_bank[b] : bus.iccm_wren_bank[b];
          a  = (m == 1) ? bus.dccm_addr_bank[b*AW +: AW] : bus.iccm_addr_bank[b*AW +: AW];
          d  = (m == 1) ? bus.dccm_wr_data_bank[b*W +: W] : bus.iccm_bank_wr_data[b*W +: W];
          key = {m[0], b[1:0], a};
          if (en && we) model_mem[key] = d ^ flip_of(m, bus.sram_error_injection_mode);
          else if (en) exp_dout[m][b] = model_mem.exists(key) ? model_mem[key] : 39'd0;
        end
      end
    end
  end

  always @(negedge rst_b) begin
    for (int m = 0; m < 2; m++)
      for (int b = 0; b < NB; b++) exp_dout[m][b] = 39'd0;
  end

  // Every-cycle comparison of all dout slices against the model.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      for (int b = 0; b < NB; b++) begin
        checks++;
        if (dout_of(m, b) !== exp_dout[m][b]) begin
          errors++;
          $display("FAIL model_dout mem=%0d bank=%0d got %h expected %h @%0t",
                   m, b, dout_of(m, b), exp_dout[m][b], $time);
        end
      end
    end
  end

  task automatic lit(string name, logic [W-1:0] got, logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h @%0t", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.iccm_clken     = 4'b0000;
    bus.iccm_wren_bank = 4'b0000;
    bus.dccm_clken     = 4'b0000;
    bus.dccm_wren_bank = 4'b0000;
  endtask

  task automatic acc(int m, int b, logic we, logic [AW-1:0] a, logic [W-1:0] d);
    if (m == 1) begin
      bus.dccm_clken[b]               = 1'b1;
      bus.dccm_wren_bank[b]           = we;
      bus.dccm_addr_bank[b*AW +: AW]  = a;
      bus.dccm_wr_data_bank[b*W +: W] = d;
    end else begin
      bus.iccm_clken[b]               = 1'b1;
      bus.iccm_wren_bank[b]           = we;
      bus.iccm_addr_bank[b*AW +: AW]  = a;
      bus.iccm_bank_wr_data[b*W +: W] = d;
    end
  endtask

  logic [AW-1:0] pool [6];

  initial begin
    for (int m = 0; m < 2; m++)
      for (int b = 0; b < NB; b++) exp_dout[m][b] = 39'd0;
    pool[0] = 13'h0000; pool[1] = 13'h0155; pool[2] = 13'h1FFF;
    pool[3] = 13'd10;   pool[4] = 13'd40;   pool[5] = 13'd1234;

    rst_b = 1'b1;
    bus.sram_error_injection_mode = 4'b0000;
    bus.iccm_addr_bank = '0; bus.iccm_bank_wr_data = '0;
    bus.dccm_addr_bank = '0; bus.dccm_wr_data_bank = '0;
    idle();
    #1 rst_b = 1'b0;
    repeat (3) tick();
    rst_b = 1'b1;
    tick();
    for (int b = 0; b < NB; b++) begin
      lit("reset_iccm", dout_of(0, b), 39'd0);
      lit("reset_dccm", dout_of(1, b), 39'd0);
    end

    // Write then read, ICCM bank 2.
    acc(0, 2, 1'b1, 13'h0155, 39'h5A_DEADBEEF);
    tick(); idle();
    acc(0, 2, 1'b0, 13'h0155, 39'd0);
    tick(); idle();
    lit("wr_rd_iccm2", dout_of(0, 2), 39'h5A_DEADBEEF);
    lit("other_bank_iccm0", dout_of(0, 0), 39'd0);
    lit("other_bank_iccm3", dout_of(0, 3), 39'd0);

    // Bank independence, DCCM top address.
    for (int b = 0; b < NB; b++) acc(1, b, 1'b1, 13'h1FFF, 39'(b + 1));
    tick(); idle();
    for (int b = 0; b < NB; b++) acc(1, b, 1'b0, 13'h1FFF, 39'd0);
    tick(); idle();
    lit("indep_dccm0", dout_of(1, 0), 39'h1);
    lit("indep_dccm1", dout_of(1, 1), 39'h2);
    lit("indep_dccm2", dout_of(1, 2), 39'h3);
    lit("indep_dccm3", dout_of(1, 3), 39'h4);

    // Single-bit injection applies to the ICCM only.
    bus.sram_error_injection_mode = 4'b0001;
    acc(0, 0, 1'b1, 13'd10, 39'd0);
    acc(1, 0, 1'b1, 13'd10, 39'd0);
    tick(); idle();
    bus.sram_error_injection_mode = 4'b0000;
    acc(0, 0, 1'b0, 13'd10, 39'd0);
    acc(1, 0, 1'b0, 13'd10, 39'd0);
    tick(); idle();
    lit("inj1_iccm", dout_of(0, 0), 39'h1);
    lit("inj1_dccm", dout_of(1, 0), 39'h0);

    // Double-bit takes precedence over single-bit.
    bus.sram_error_injection_mode = 4'b1100;
    acc(1, 1, 1'b1, 13'd20, 39'h7F_FFFFFFFF);
    tick(); idle();
    bus.sram_error_injection_mode = 4'b0000;
    acc(1, 1, 1'b0, 13'd20, 39'd0);
    tick(); idle();
    lit("inj2_dccm", dout_of(1, 1), 39'h7F_FFFFFFFC);

    // A write does not update dout.
    acc(1, 3, 1'b1, 13'd30, 39'h11);
    tick(); idle();
    acc(1, 3, 1'b0, 13'd30, 39'd0);
    tick(); idle();
    lit("rd_A", dout_of(1, 3), 39'h11);
    acc(1, 3, 1'b1, 13'd31, 39'h22);
    tick(); idle();
    lit("no_write_through", dout_of(1, 3), 39'h11);

    // Hold, async reset, contents preserved.
    acc(0, 1, 1'b1, 13'd40, 39'h12345678);
    tick(); idle();
    acc(0, 1, 1'b0, 13'd40, 39'd0);
    tick(); idle();
    lit("hold_rd", dout_of(0, 1), 39'h12345678);
    for (int i = 0; i < 5; i++) begin
      tick();
      lit("hold", dout_of(0, 1), 39'h12345678);
    end
    #1 rst_b = 1'b0;
    #1 lit("async_reset", dout_of(0, 1), 39'd0);
    tick();
    rst_b = 1'b1;
    tick();
    lit("after_reset_hold", dout_of(0, 1), 39'd0);
    acc(0, 1, 1'b0, 13'd40, 39'd0);
    tick(); idle();
    lit("preserved", dout_of(0, 1), 39'h12345678);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      idle();
      bus.sram_error_injection_mode = 4'($urandom);
      for (int m = 0; m < 2; m++) begin
        for (int b = 0; b < NB; b++) begin
          if ($urandom_range(2, 0) != 0) begin
            acc(m, b, ($urandom_range(2, 0) == 0),
                pool[$urandom_range(5, 0)],
                {7'($urandom), 32'($urandom)});
          end
        end
      end
      if ($urandom_range(49, 0) == 0) begin
        @(posedge clk);
        #3 rst_b = 1'b0;
        #1 rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
      end else begin
        tick();
      end
    end

    idle();
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
